// File: rtl/fanin_merge_pkg.sv
// fanin_merge_pkg: shared state type, default sizes and index-width helper for fanin_merge
package fanin_merge_pkg;
   typedef enum logic {EMPTY, FULL} state_t;
   localparam int NUM_SRC_DEF = 4;
   localparam int DATA_W_DEF = 8;
   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/fanin_merge_rr_arbiter.sv
// rr_arbiter: round-robin search starting at ptr, wrapping from N-1 to 0
module rr_arbiter import fanin_merge_pkg::*; #(
   parameter int N = NUM_SRC_DEF,
   parameter int IW = idx_w(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   input  logic          enable,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          any_grant
);
   // scan farthest offset first so the nearest requester to ptr wins
   always_comb begin
      grant_idx = '0;
      any_grant = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (enable && req[(int'(ptr) + k) % N]) begin
            grant_idx = IW'((int'(ptr) + k) % N);
            any_grant = 1'b1;
         end
      end
      grant = any_grant ? (N'(1) << grant_idx) : '0;
   end
endmodule

// File: rtl/fanin_merge.sv
// fanin_merge: round-robin merge of NUM_SRC valid/ready sources into one registered output
module fanin_merge import fanin_merge_pkg::*; #(
   parameter int NUM_SRC = NUM_SRC_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_SRC-1:0]        src_valid,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   output logic [NUM_SRC-1:0]        src_ready,
   output logic                      out_valid,
   output logic [DATA_W-1:0]         out_data,
   output logic [idx_w(NUM_SRC)-1:0] out_src,
   input  logic                      out_ready,
   output logic [15:0]               xfer_count
);
   localparam int IW = idx_w(NUM_SRC);
   state_t        state;
   logic [IW-1:0] ptr;
   logic [IW-1:0] grant_idx;
   logic          any_grant;
   logic          enable;
   // a new word may enter only when the output register is empty or draining this cycle
   assign enable = !rst && (state == EMPTY || out_ready);
   assign out_valid = (state == FULL);
   rr_arbiter #(.N(NUM_SRC), .IW(IW)) u_arb (
      .req(src_valid),
      .ptr(ptr),
      .enable(enable),
      .grant(src_ready),
      .grant_idx(grant_idx),
      .any_grant(any_grant)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= EMPTY;
         out_data <= '0;
         out_src <= '0;
         ptr <= '0;
         xfer_count <= '0;
      end else begin
         if (state == FULL && out_ready) xfer_count <= xfer_count + 16'd1;
         if (any_grant) begin
            state <= FULL;
            out_data <= src_data[grant_idx*DATA_W +: DATA_W];
            out_src <= grant_idx;
            ptr <= (grant_idx == IW'(NUM_SRC - 1)) ? '0 : grant_idx + IW'(1);
         end else if (state == FULL && out_ready) begin
            state <= EMPTY;
         end
      end
   end
endmodule

// File: tb/tb_fanin_merge.sv
// tb_fanin_merge: table-driven directed checks plus a long counter-wrap stream
module tb_fanin_merge;
   typedef struct {
      logic        rst;
      logic [3:0]  sv;
      logic [31:0] sd;
      logic        ordy;
      logic [3:0]  sr;
      logic        ov;
      logic [7:0]  od;
      logic [1:0]  os;
      logic [15:0] cnt;
   } vec_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  src_valid = '0;
   logic [31:0] src_data = '0;
   logic [3:0]  src_ready;
   logic        out_valid;
   logic [7:0]  out_data;
   logic [1:0]  out_src;
   logic        out_ready = 1'b0;
   logic [15:0] xfer_count;
   int checks = 0;
   int failures = 0;
   vec_t vt[$];
   localparam logic [31:0] DN = 32'h33221100;
   localparam logic [31:0] DA = 32'h3322A500;
   localparam logic [31:0] DC = 32'h333C1100;
   fanin_merge #(.NUM_SRC(4), .DATA_W(8)) dut (
      .clk(clk),
      .rst(rst),
      .src_valid(src_valid),
      .src_data(src_data),
      .src_ready(src_ready),
      .out_valid(out_valid),
      .out_data(out_data),
      .out_src(out_src),
      .out_ready(out_ready),
      .xfer_count(xfer_count)
   );
   always #5 clk = ~clk;
   function automatic vec_t mk(logic r, logic [3:0] sv, logic [31:0] sd, logic ordy, logic [3:0] sr,
                               logic ov, logic [7:0] od, logic [1:0] os, logic [15:0] cnt);
      vec_t v;
      v.rst = r; v.sv = sv; v.sd = sd; v.ordy = ordy; v.sr = sr;
      v.ov = ov; v.od = od; v.os = os; v.cnt = cnt;
      return v;
   endfunction
   task automatic chk(input string name, input int idx, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s vec=%0d got=%0h expected=%0h", name, idx, act, exp);
      end
   endtask
   initial begin
      vt.push_back(mk(1, 4'hF, DN, 1, 4'b0000, 0, 8'h00, 0, 0));
      vt.push_back(mk(0, 4'hF, DN, 1, 4'b0001, 1, 8'h00, 0, 0));
      vt.push_back(mk(0, 4'hF, DN, 1, 4'b0010, 1, 8'h11, 1, 1));
      vt.push_back(mk(0, 4'hF, DN, 1, 4'b0100, 1, 8'h22, 2, 2));
      vt.push_back(mk(0, 4'hF, DN, 1, 4'b1000, 1, 8'h33, 3, 3));
      vt.push_back(mk(0, 4'hF, DN, 1, 4'b0001, 1, 8'h00, 0, 4));
      vt.push_back(mk(0, 4'h0, DN, 1, 4'b0000, 0, 8'h00, 0, 5));
      vt.push_back(mk(0, 4'h2, DA, 0, 4'b0010, 1, 8'hA5, 1, 5));
      for (int i = 0; i < 4; i++) vt.push_back(mk(0, 4'h2, DA, 0, 4'b0000, 1, 8'hA5, 1, 5));
      vt.push_back(mk(0, 4'h0, DA, 1, 4'b0000, 0, 8'hA5, 1, 6));
      vt.push_back(mk(0, 4'h0, DN, 1, 4'b0000, 0, 8'hA5, 1, 6));
      vt.push_back(mk(0, 4'h4, DC, 1, 4'b0100, 1, 8'h3C, 2, 6));
      vt.push_back(mk(0, 4'h0, DC, 1, 4'b0000, 0, 8'h3C, 2, 7));
      vt.push_back(mk(0, 4'h9, DN, 1, 4'b1000, 1, 8'h33, 3, 7));
      vt.push_back(mk(0, 4'h9, DN, 1, 4'b0001, 1, 8'h00, 0, 8));
      vt.push_back(mk(0, 4'h0, DN, 1, 4'b0000, 0, 8'h00, 0, 9));
      vt.push_back(mk(0, 4'h4, DN, 0, 4'b0100, 1, 8'h22, 2, 9));
      vt.push_back(mk(1, 4'hF, DN, 0, 4'b0000, 0, 8'h00, 0, 0));
      vt.push_back(mk(1, 4'hF, DN, 0, 4'b0000, 0, 8'h00, 0, 0));
      vt.push_back(mk(0, 4'h0, DN, 0, 4'b0000, 0, 8'h00, 0, 0));
      vt.push_back(mk(0, 4'hF, DN, 1, 4'b0001, 1, 8'h00, 0, 0));
      foreach (vt[i]) begin
         @(negedge clk);
         rst = vt[i].rst;
         src_valid = vt[i].sv;
         src_data = vt[i].sd;
         out_ready = vt[i].ordy;
         #1;
         chk("src_ready", i, src_ready, vt[i].sr);
         @(posedge clk);
         #1;
         chk("out_valid", i, out_valid, vt[i].ov);
         chk("out_data", i, out_data, vt[i].od);
         chk("out_src", i, out_src, vt[i].os);
         chk("xfer_count", i, xfer_count, vt[i].cnt);
      end
      // counter wrap: the first edge only loads, every later edge transfers one word
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      src_valid = 4'hF;
      src_data = DN;
      out_ready = 1'b1;
      repeat (65536) @(posedge clk);
      #1;
      chk("cnt_65535", -1, xfer_count, 16'hFFFF);
      chk("cnt_stream_valid", -1, out_valid, 1);
      @(posedge clk);
      #1;
      chk("cnt_wrap", -1, xfer_count, 16'h0000);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fanin_merge.md
FANIN_MERGE -- requirements
Module: fanin_merge

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4, number of source ports (2..8).
REQ-002 SHALL have parameter DATA_W, default 8, payload width per source.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-005 SHALL have port src_valid, input, NUM_SRC, per-source request.
REQ-006 SHALL have port src_data, input, NUM_SRC*DATA_W, packed payloads; source i occupies bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port src_ready, output, NUM_SRC, per-source accept strobe.
REQ-008 SHALL have port out_valid, output, 1, the output register holds a word.
REQ-009 SHALL have port out_data, output, DATA_W, registered payload.
REQ-010 SHALL have port out_src, output, clog2(NUM_SRC), index of the source that supplied out_data.
REQ-011 SHALL have port out_ready, input, 1, downstream accept.
REQ-012 SHALL have port xfer_count, output, 16, count of completed output transfers.

Function
REQ-013 SHALL merge NUM_SRC valid/ready sources onto one registered valid/ready output; transfer occurs on any edge where valid and ready are both high.
REQ-014 SHALL implement FSM states EMPTY (out register empty) and FULL (out register holds a word).
REQ-015 SHALL, in EMPTY, grant one requesting source, load its data and index, and go FULL; with no request, remain EMPTY.
REQ-016 SHALL, in FULL with out_ready high, complete the output transfer and in the same cycle grant and load a new word if any source requests (stay FULL), else go EMPTY.
REQ-017 SHALL, in FULL with out_ready low, hold out_data/out_src stable, grant nothing, and drive all src_ready low.
REQ-018 SHALL assert at most one src_ready bit per cycle, and only for a source whose src_valid is high; src_ready is combinational from src_valid, state, out_ready, and pointer.
REQ-019 SHALL arbitrate round-robin: search starts at index ptr, wrapping from NUM_SRC-1 to 0; after a grant to index g, ptr becomes (g+1) mod NUM_SRC; ptr unchanged when no grant.
REQ-020 SHALL produce 1-cycle latency: data accepted at edge N appears on out_data after edge N.
REQ-021 SHALL sustain one transfer per cycle while out_ready stays high and requests are present.
REQ-022 SHALL increment xfer_count by 1 per output transfer, wrapping 16'hFFFF to 0.
REQ-023 SHALL not drop or duplicate any word; a source whose src_valid is high but not granted is not consumed.

Reset
REQ-024 SHALL, with rst high at an edge, force state EMPTY, out_valid 0, out_data 0, out_src 0, ptr 0, xfer_count 0, regardless of in-flight handshakes.
REQ-025 SHALL drive all src_ready low while rst is high; a word held in FULL when reset asserts is discarded.

Structure
REQ-026 SHALL place the state enum (EMPTY, FULL), default NUM_SRC, DATA_W, and the index width function in package fanin_merge_pkg.
REQ-027 SHALL implement the pointer-based priority search as one sub-module rr_arbiter (inputs req, ptr, enable; outputs one-hot grant, grant index, any_grant).
REQ-028 SHALL contain no latches, no combinational loops, and no asynchronous logic.

Verification
REQ-029 SHALL cover reset: rst high 2 cycles mid-FULL with out_ready=0 -> out_valid=0, xfer_count=0, src_ready=0 throughout, EMPTY after release.
REQ-030 SHALL cover fairness: all 4 sources valid continuously, out_ready=1 -> out_src sequence 0,1,2,3,0,1..., one word per cycle, xfer_count increments every cycle.
REQ-031 SHALL cover backpressure: src1 valid with data 8'hA5, out_ready=0 for 5 cycles -> out_data=8'hA5, out_src=1 held, src_ready all 0 after first accept, single transfer when out_ready rises.
REQ-032 SHALL cover wrap: ptr=3 (after grant to 2), sources 0 and 3 valid -> grant 3 then 0.
REQ-033 SHALL cover sparse input: only src2 valid with 8'h3C, out_ready=1 -> out_valid high exactly the next cycle with out_data=8'h3C, then EMPTY.
REQ-034 SHALL cover counter wrap: force 65535 transfers (or preload via reset sequence and stream) -> xfer_count returns to 0 on the 65536th transfer.
